// File: rtl/gb_bus_pkg.sv
// Shared Game Boy bus definitions: OAM DMA state encoding, fixed register
// addresses and the echo-RAM source remap.
package gb_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WAIT  = 2'd3
  } dma_state_t;

  localparam logic [15:0] REG_ADDR = 16'hff46;
  localparam logic [15:0] OAM_BASE = 16'hfe00;

  // Pages E0-FF alias the work RAM 0x2000 lower (FE/FF read as DE/DF).
  function automatic logic [7:0] src_map(input logic [7:0] hi);
    return (hi >= 8'he0) ? (hi - 8'h20) : hi;
  endfunction

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator: a CPU write to FF46 copies XFER_LEN bytes from page XX to OAM.
// Define DMA_PACING_EN to stretch each byte to BYTE_CYCLES clocks with a WAIT state.
module oam_dma
  import gb_bus_pkg::*;
#(
  parameter int XFER_LEN    = 160,
  parameter int BYTE_CYCLES = 4
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic [15:0] cpu_address,
  input  logic [7:0]  cpu_indata,
  output logic [7:0]  cpu_outdata,
  input  logic        cpu_load,
  input  logic        cpu_store,
  output logic [15:0] address,
  output logic [7:0]  outdata,
  input  logic [7:0]  indata,
  output logic        load,
  output logic        store,
  output logic        busy
);

`ifdef DMA_PACING_EN
  localparam bit PACED = (BYTE_CYCLES > 2);
`else
  localparam bit PACED = 1'b0;
`endif
  localparam logic [7:0] WAIT_LAST = 8'((BYTE_CYCLES > 2) ? (BYTE_CYCLES - 3) : 0);
  localparam logic [7:0] IDX_LAST  = 8'(XFER_LEN - 1);

  dma_state_t  state, state_nx;
  logic [7:0]  src_reg, src_nx;
  logic [7:0]  idx, idx_nx;
  logic [7:0]  wcnt, wcnt_nx;
  logic [15:0] address_nx;
  logic [7:0]  outdata_nx;
  logic        load_nx, store_nx, busy_nx;
  logic        reg_wr, reg_rd, last;

  assign reg_wr = cpu_store && (cpu_address == REG_ADDR);
  assign reg_rd = cpu_load && (cpu_address == REG_ADDR);
  assign last   = (idx == IDX_LAST);

  // Outputs are decoded from the state being entered so every bus signal is a flop.
  always_comb begin
    state_nx   = state;
    src_nx     = src_reg;
    idx_nx     = idx;
    wcnt_nx    = wcnt;
    load_nx    = 1'b0;
    store_nx   = 1'b0;
    address_nx = '0;
    outdata_nx = '0;
    if (reg_wr) begin
      src_nx   = cpu_indata;
      idx_nx   = '0;
      state_nx = ST_READ;
    end else begin
      case (state)
        ST_READ:  state_nx = ST_WRITE;
        ST_WRITE: begin
          if (PACED) begin
            state_nx = ST_WAIT;
            wcnt_nx  = WAIT_LAST;
          end else if (last) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_READ;
            idx_nx   = idx + 8'd1;
          end
        end
        ST_WAIT: begin
          if (wcnt != 8'd0) begin
            wcnt_nx = wcnt - 8'd1;
          end else if (last) begin
            state_nx = ST_IDLE;
          end else begin
            state_nx = ST_READ;
            idx_nx   = idx + 8'd1;
          end
        end
        default:  state_nx = ST_IDLE;
      endcase
    end
    case (state_nx)
      ST_READ: begin
        load_nx    = 1'b1;
        address_nx = {src_map(src_nx), idx_nx};
      end
      ST_WRITE: begin
        store_nx   = 1'b1;
        address_nx = OAM_BASE + {8'h00, idx_nx};
        outdata_nx = indata;
      end
      default: ;
    endcase
    busy_nx = (state_nx != ST_IDLE);
  end

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      src_reg     <= 8'hff;
      idx         <= '0;
      wcnt        <= '0;
      address     <= '0;
      outdata     <= '0;
      load        <= 1'b0;
      store       <= 1'b0;
      busy        <= 1'b0;
      cpu_outdata <= '0;
    end else begin
      state       <= state_nx;
      src_reg     <= src_nx;
      idx         <= idx_nx;
      wcnt        <= wcnt_nx;
      address     <= address_nx;
      outdata     <= outdata_nx;
      load        <= load_nx;
      store       <= store_nx;
      busy        <= busy_nx;
      cpu_outdata <= reg_rd ? src_reg : 8'h00;
    end
  end

endmodule
